// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter that shares one registered CDB slot among N result ports.
// One winner per cycle is picked from a rotating pointer and held until the consumers accept it.
module cdb_rr_arbiter #(
  parameter int N      = 8,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [N-1:0]                  valid_i,
  output logic [N-1:0]                  ready_o,
  input  logic [N-1:0][DATA_W-1:0]      data_i,
  input  logic [N-1:0][TAG_W-1:0]       tag_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_W-1:0]             data_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic [$clog2(N)-1:0]          src_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] ptr_nxt;
  logic             grant_vld;
  logic             can_load;
  logic             xfer_in;
  int               cand;

  // Scan from the pointer upwards with explicit wrap, so non-power-of-two N never
  // produces an out-of-range index.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write; otherwise
    // the missing paths infer latches.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!grant_vld && valid_i[IDX_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign can_load = !valid_o || ready_i;
  assign xfer_in  = grant_vld && can_load && !flush_i;
  assign ptr_nxt  = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    ready_o = '0;
    if (xfer_in) ready_o[grant_idx] = 1'b1;
  end

  // Flush wins over both a pending grant and an output transfer; payload holds so
  // the last entry stays observable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: state updates use non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      ptr     <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      tag_o   <= '0;
      src_o   <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (xfer_in) begin
      valid_o <= 1'b1;
      data_o  <= data_i[grant_idx];
      tag_o   <= tag_i[grant_idx];
      src_o   <= grant_idx;
      ptr     <= ptr_nxt;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/cdb_rr_arbiter.md
# cdb_rr_arbiter

Round-robin arbiter sharing the common data bus (CDB) among N execution-unit result ports. Each cycle it selects one valid requester starting from a rotating priority pointer, captures its result into a single output register and presents it to the CDB consumers (reservation stations, ROB) with a valid/ready handshake. Fairness: any requester that holds `valid_i` is granted within N transfers.

## Interface
- `N`, 8: number of requesters; N ≥ 2, need not be a power of two.
- `DATA_W`, 64: result data width.
- `TAG_W`, 6: ROB tag width.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous pipeline flush.
- `valid_i`  in  N  per-requester result valid.
- `ready_o`  out  N  per-requester accept, one-hot or zero.
- `data_i`  in  N×DATA_W  per-requester result data.
- `tag_i`  in  N×TAG_W  per-requester ROB tag.
- `valid_o`  out  1  CDB entry valid.
- `ready_i`  in  1  CDB consumers accept.
- `data_o`  out  DATA_W  registered result data.
- `tag_o`  out  TAG_W  registered ROB tag.
- `src_o`  out  $clog2(N)  index of the requester that produced the current entry.

## Operation
- State: priority pointer `ptr` (range 0..N-1), output register {`valid_o`, `data_o`, `tag_o`, `src_o`}.
- Reset values: `ptr`=0, `valid_o`=0, `data_o`=0, `tag_o`=0, `src_o`=0. `ready_o` is then 0 until a requester is valid.
- Selection (combinational): scan indices `ptr`, `ptr`+1, …, N-1, 0, …, `ptr`-1; the first index with `valid_i` set is `g`. The lower rotated position has the higher priority. There is no grant if no input is valid.
- `can_load` = !`valid_o` | `ready_i`: the register is empty or drains this cycle.
- `ready_o[g]` = `can_load` & !`flush_i`. All other `ready_o` bits are 0.
- Input transfer: a grant exists and `ready_o[g]`=1. On the next edge:
  - `data_o`←`data_i[g]`, `tag_o`←`tag_i[g]`, `src_o`←g, `valid_o`←1.
  - `ptr`←(g+1) mod N. Wrap is explicit: g=N-1 gives 0.
- Output transfer: `valid_o` & `ready_i`. If no input transfer happens in the same cycle, `valid_o`←0 and `data_o`/`tag_o`/`src_o` hold their values.
- Simultaneous output and input transfer: the register reloads with the new winner and `valid_o` stays 1. This sustains 1 result/cycle.
- Stall (`valid_o`=1, `ready_i`=0): the register holds; all `ready_o`=0; `ptr` holds.
- Output stability: once `valid_o`=1, `data_o`/`tag_o`/`src_o` are stable until the output transfer.
- Flush (`flush_i`=1), on the next edge:
  - `valid_o`←0, no input transfer, `ptr` unchanged.
  - `ready_o` is forced to 0 in the flush cycle.
  - `data_o`/`tag_o`/`src_o` hold.
  - Flush overrides a simultaneous output transfer and a pending grant.
- Reset mid-operation: asynchronous clear to reset values. An in-flight entry is discarded.
- Requesters may drop `valid_i` without being granted. The arbiter keeps no per-requester state.

## Timing
- Latency: input transfer at edge k gives `valid_o`=1 after edge k. That is 1 cycle; there is no combinational path from `data_i` to `data_o`.
- Combinational paths:
  - `valid_i` → `ready_o`.
  - `ready_i` → `ready_o`.
  - `flush_i` → `ready_o`.
  - There is no path from `valid_i` to `valid_o`.
- Throughput: 1 transfer/cycle with `ready_i` held at 1.
- Starvation bound: a requester continuously valid from cycle t is granted within N input transfers after t.

## Test plan
- Reset: assert `rst_n_i`=0 mid-cycle with `valid_o`=1 → immediately `valid_o`=0, `ptr`=0; after release with `valid_i`=8'h00 → `ready_o`=0.
- All-valid rotation (N=8, `valid_i`=8'hFF, `ready_i`=1 constant) → `src_o` sequence is 0,1,2,…,7,0,1 on consecutive cycles; exactly one `ready_o` bit is set per cycle.
- Wrap and skip: `ptr`=6, `valid_i` bits {1,3} set → grant 1 first, then 3; `ptr` becomes 2, then 4.
- Back-pressure: `valid_i[2]`=1 with tag 0x15 and data 0xDEAD, then `ready_i`=0 for 3 cycles:
  - `valid_o`=1 with `tag_o`=0x15 held for the 3 cycles and `ready_o`=0 throughout.
  - `ready_i`=1 → transfer, and requester 2 is reloaded in the same cycle if still valid.
- Flush: flush in the same cycle as `valid_o`=1 and `ready_i`=1 with `valid_i`=8'h10 → `ready_o`=0, `valid_o`=0 next cycle, `ptr` unchanged; requester 4 is granted the cycle after.
- Fairness with N=5 (non-power-of-two): `valid_i`=5'b11111 for 12 cycles with random `ready_i` → each index is granted within any 5 consecutive transfers, `src_o` is never ≥5, and a scoreboard matches every data/tag pair.
